// File: rtl/area_scan_ctrl.sv
// area_scan_ctrl: raster scan of a ROWS x COLS pixel matrix with a 4-stage ring animation.
// rev 1.0 -- initial release
`default_nettype none

module area_scan_ctrl #(
  parameter logic [6:0] ROWS        = 7'd54,
  parameter logic [6:0] COLS        = 7'd64,
  parameter logic [7:0] HOLD_FRAMES = 8'd4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       pix_ready,
  input  logic       judge1,
  input  logic       judge2,
  input  logic       judge3,
  output logic [6:0] row_now,
  output logic [6:0] col_now,
  output logic       pix_valid,
  output logic       pix_on,
  output logic [1:0] stage,
  output logic       frame_done,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_FEND = 2'd2
  } state_t;

  state_t      r_state;
  logic [6:0]  r_row;
  logic [6:0]  r_col;
  logic        r_valid;
  logic        r_fdone;
  logic        r_busy;
  logic [1:0]  r_stage;
  logic [7:0]  r_frame_cnt;
  logic        r_stop_pend;

  logic        w_adv;
  logic        w_last_col;
  logic        w_last_row;
  logic        w_last_hold;
  logic        w_ring;

  assign w_adv       = r_valid & pix_ready;
  assign w_last_col  = (r_col >= COLS - 7'd1);
  assign w_last_row  = (r_row >= ROWS - 7'd1);
  assign w_last_hold = (r_frame_cnt >= HOLD_FRAMES - 8'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_row       <= 7'd0;
      r_col       <= 7'd0;
      r_valid     <= 1'b0;
      r_fdone     <= 1'b0;
      r_busy      <= 1'b0;
      r_stage     <= 2'd0;
      r_frame_cnt <= 8'd0;
      r_stop_pend <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // start wins over a simultaneous stop; stop is not latched while idle
          if (start) begin
            r_state <= S_SCAN;
            r_row   <= 7'd0;
            r_col   <= 7'd0;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
          end
        end

        S_SCAN: begin
          if (stop) begin
            r_stop_pend <= 1'b1;
          end
          if (w_adv) begin
            if (!w_last_col) begin
              r_col <= r_col + 7'd1;
            end else begin
              r_col <= 7'd0;
              if (!w_last_row) begin
                r_row <= r_row + 7'd1;
              end else begin
                r_row   <= 7'd0;
                r_state <= S_FEND;
                r_valid <= 1'b0;
                r_fdone <= 1'b1;
              end
            end
          end
        end

        S_FEND: begin
          r_fdone <= 1'b0;
          if (w_last_hold) begin
            r_frame_cnt <= 8'd0;
            r_stage     <= r_stage + 2'd1;
          end else begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
          end
          // a stop arriving on the boundary cycle itself also halts here
          if (r_stop_pend || stop) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_stop_pend <= 1'b0;
          end else begin
            r_state <= S_SCAN;
            r_valid <= 1'b1;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_row       <= 7'd0;
          r_col       <= 7'd0;
          r_valid     <= 1'b0;
          r_fdone     <= 1'b0;
          r_busy      <= 1'b0;
          r_stop_pend <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    w_ring = 1'b0;
    case (r_stage)
      2'd0:    w_ring = judge1;
      2'd1:    w_ring = judge1 | judge2;
      2'd2:    w_ring = judge1 | judge2 | judge3;
      default: w_ring = 1'b0;
    endcase
  end

  assign row_now    = r_row;
  assign col_now    = r_col;
  assign pix_valid  = r_valid;
  assign pix_on     = r_valid & w_ring;
  assign stage      = r_stage;
  assign frame_done = r_fdone;
  assign busy       = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_area_scan_ctrl.sv
// tb_area_scan_ctrl: directed checks of scan order, backpressure, stages, stop and reset.
// rev 1.0 -- initial release
`default_nettype none

module tb_area_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic       pix_ready;

  // small instance: 3x4 matrix, 2 frames per stage
  logic       s_start, s_stop, s_j1, s_j2, s_j3, jpat;
  logic [6:0] s_row, s_col;
  logic       s_valid, s_on, s_fd, s_busy;
  logic [1:0] s_stage;

  // default-size instance, one frame per stage, for the ring-select case
  logic       b_start, b_stop, b_j3;
  logic [6:0] b_row, b_col;
  logic       b_valid, b_on, b_fd, b_busy;
  logic [1:0] b_stage;

  int n_tests;
  int n_fail;

  assign s_j1 = jpat ? (s_row[0] ^ s_col[0]) : 1'b1;
  assign s_j2 = jpat ? 1'b0 : 1'b1;
  assign s_j3 = jpat ? 1'b0 : 1'b1;
  assign b_j3 = (b_row == 7'd52) && (b_col == 7'd0);

  area_scan_ctrl #(.ROWS(7'd3), .COLS(7'd4), .HOLD_FRAMES(8'd2)) u_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .stop(s_stop), .pix_ready(pix_ready),
    .judge1(s_j1), .judge2(s_j2), .judge3(s_j3),
    .row_now(s_row), .col_now(s_col), .pix_valid(s_valid), .pix_on(s_on),
    .stage(s_stage), .frame_done(s_fd), .busy(s_busy)
  );

  area_scan_ctrl #(.ROWS(7'd54), .COLS(7'd64), .HOLD_FRAMES(8'd1)) u_big (
    .clk(clk), .rst_n(rst_n), .start(b_start), .stop(b_stop), .pix_ready(pix_ready),
    .judge1(1'b0), .judge2(1'b0), .judge3(b_j3),
    .row_now(b_row), .col_now(b_col), .pix_valid(b_valid), .pix_on(b_on),
    .stage(b_stage), .frame_done(b_fd), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pos(input logic [6:0] r, input logic [6:0] c, input int maxc, input string tag);
    int n = 0;
    while (!(s_valid && s_row == r && s_col == c) && n < maxc) begin
      step();
      n++;
    end
    chk(tag, {31'd0, (s_valid && s_row == r && s_col == c)}, 32'd1);
  endtask

  task automatic wait_fd(input int maxc, input string tag);
    int n = 0;
    while (!s_fd && n < maxc) begin
      step();
      n++;
    end
    chk(tag, {31'd0, s_fd}, 32'd1);
  endtask

  task automatic chk_small_idle(input string tag);
    chk({tag, "_row"},  {25'd0, s_row}, 32'd0);
    chk({tag, "_col"},  {25'd0, s_col}, 32'd0);
    chk({tag, "_vld"},  {31'd0, s_valid}, 32'd0);
    chk({tag, "_on"},   {31'd0, s_on}, 32'd0);
    chk({tag, "_fd"},   {31'd0, s_fd}, 32'd0);
    chk({tag, "_busy"}, {31'd0, s_busy}, 32'd0);
  endtask

  initial begin
    int n;
    logic [1:0] exp_stage;
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    pix_ready = 1'b1;
    s_start   = 1'b0;
    s_stop    = 1'b0;
    b_start   = 1'b0;
    b_stop    = 1'b0;
    jpat      = 1'b0;

    repeat (3) step();
    chk_small_idle("rst");
    chk("rst_stage", {30'd0, s_stage}, 32'd0);
    rst_n = 1'b1;
    repeat (3) step();
    chk_small_idle("post_rst");

    // ring select on the full-size matrix
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    n = 0;
    while (!(b_valid && b_row == 7'd52 && b_col == 7'd0 && b_stage == 2'd1) && n < 8000) begin
      step();
      n++;
    end
    chk("ring_s1_found", {31'd0, (b_valid && b_row == 7'd52 && b_col == 7'd0 && b_stage == 2'd1)}, 32'd1);
    chk("ring_s1_on", {31'd0, b_on}, 32'd0);
    n = 0;
    while (!(b_valid && b_row == 7'd52 && b_col == 7'd0 && b_stage == 2'd2) && n < 5000) begin
      step();
      n++;
    end
    chk("ring_s2_found", {31'd0, (b_valid && b_row == 7'd52 && b_col == 7'd0 && b_stage == 2'd2)}, 32'd1);
    chk("ring_s2_on", {31'd0, b_on}, 32'd1);
    b_stop = 1'b1;
    step();
    b_stop = 1'b0;
    n = 0;
    while (b_busy && n < 5000) begin
      step();
      n++;
    end
    chk("big_stop_idle", {31'd0, b_busy}, 32'd0);

    // scan order and stage walk, all judges high
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    chk("start_busy", {31'd0, s_busy}, 32'd1);
    for (int f = 0; f < 9; f++) begin
      exp_stage = 2'((f / 2) % 4);
      for (int k = 0; k < 12; k++) begin
        chk($sformatf("f%0d_k%0d_row", f, k), {25'd0, s_row}, 32'(k / 4));
        chk($sformatf("f%0d_k%0d_col", f, k), {25'd0, s_col}, 32'(k % 4));
        chk($sformatf("f%0d_k%0d_vld", f, k), {31'd0, s_valid}, 32'd1);
        chk($sformatf("f%0d_k%0d_stg", f, k), {30'd0, s_stage}, {30'd0, exp_stage});
        chk($sformatf("f%0d_k%0d_on", f, k), {31'd0, s_on}, (exp_stage != 2'd3) ? 32'd1 : 32'd0);
        chk($sformatf("f%0d_k%0d_fd", f, k), {31'd0, s_fd}, 32'd0);
        step();
      end
      chk($sformatf("f%0d_fend_fd", f), {31'd0, s_fd}, 32'd1);
      chk($sformatf("f%0d_fend_vld", f), {31'd0, s_valid}, 32'd0);
      chk($sformatf("f%0d_fend_on", f), {31'd0, s_on}, 32'd0);
      chk($sformatf("f%0d_fend_pos", f), {18'd0, s_row, s_col}, 32'd0);
      chk($sformatf("f%0d_fend_busy", f), {31'd0, s_busy}, 32'd1);
      step();
    end
    chk("walk_fcnt", {24'd0, u_small.r_frame_cnt}, 32'd1);

    // backpressure at (1,2): pattern lights (1,2), not (1,3)
    jpat = 1'b1;
    wait_pos(7'd1, 7'd2, 20, "bp_reach");
    chk("bp_on0", {31'd0, s_on}, 32'd1);
    pix_ready = 1'b0;
    step();
    chk("bp_hold1_pos", {18'd0, s_row, s_col}, {18'd0, 7'd1, 7'd2});
    chk("bp_hold1_on", {31'd0, s_on}, 32'd1);
    chk("bp_hold1_vld", {31'd0, s_valid}, 32'd1);
    step();
    chk("bp_hold2_pos", {18'd0, s_row, s_col}, {18'd0, 7'd1, 7'd2});
    chk("bp_hold2_on", {31'd0, s_on}, 32'd1);
    pix_ready = 1'b1;
    step();
    chk("bp_next_pos", {18'd0, s_row, s_col}, {18'd0, 7'd1, 7'd3});
    chk("bp_next_on", {31'd0, s_on}, 32'd0);

    // stop at (0,1) of the next frame
    wait_pos(7'd0, 7'd1, 20, "stop_reach");
    s_stop = 1'b1;
    step();
    s_stop = 1'b0;
    chk("stop_busy_mid", {31'd0, s_busy}, 32'd1);
    wait_fd(20, "stop_fd");
    step();
    chk_small_idle("stop_idle");
    chk("stop_stage", {30'd0, s_stage}, 32'd1);
    chk("stop_fcnt", {24'd0, u_small.r_frame_cnt}, 32'd1);
    repeat (3) step();
    chk("idle_stay", {31'd0, s_busy}, 32'd0);

    // start and stop together: start wins and no stop is latched
    s_start = 1'b1;
    s_stop  = 1'b1;
    step();
    s_start = 1'b0;
    s_stop  = 1'b0;
    chk("ss_busy", {31'd0, s_busy}, 32'd1);
    chk("ss_vld", {31'd0, s_valid}, 32'd1);
    chk("ss_pos", {18'd0, s_row, s_col}, 32'd0);
    wait_fd(20, "ss_fd");
    step();
    chk("ss_cont_busy", {31'd0, s_busy}, 32'd1);
    chk("ss_cont_vld", {31'd0, s_valid}, 32'd1);
    chk("ss_stage", {30'd0, s_stage}, 32'd2);

    // asynchronous reset mid-frame at (1,1), stage 2
    jpat = 1'b0;
    wait_pos(7'd1, 7'd1, 20, "rst_reach");
    chk("rst_pre_on", {31'd0, s_on}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_small_idle("arst");
    chk("arst_stage", {30'd0, s_stage}, 32'd0);
    chk("arst_fcnt", {24'd0, u_small.r_frame_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    chk_small_idle("arst_rel");
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    chk("restart_busy", {31'd0, s_busy}, 32'd1);
    chk("restart_vld", {31'd0, s_valid}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/area_scan_ctrl.md
AREA_SCAN_CTRL -- requirements
Module: area_scan_ctrl

Interface
REQ-001 The block SHALL have parameter ROWS, default 7'd54, meaning the number of matrix rows scanned (0..ROWS-1).
REQ-002 The block SHALL have parameter COLS, default 7'd64, meaning the number of matrix columns scanned (0..COLS-1).
REQ-003 The block SHALL have parameter HOLD_FRAMES, default 8'd4, meaning the number of complete frames per animation stage (1..255).
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  pulse that begins continuous scanning from IDLE.
REQ-007 stop  input  1  pulse that requests a halt at the next frame boundary.
REQ-008 pix_ready  input  1  downstream accepts the current pixel.
REQ-009 judge1, judge2, judge3  input  1 each  combinational ring decodes for the current row_now/col_now.
REQ-010 row_now  output  7  current scan row.
REQ-011 col_now  output  7  current scan column.
REQ-012 pix_valid  output  1  current pixel is presented.
REQ-013 pix_on  output  1  current pixel is lit.
REQ-014 stage  output  2  current animation stage.
REQ-015 frame_done  output  1  single-cycle pulse at the end of each frame.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, SCAN and FEND.
REQ-018 IDLE->SCAN SHALL occur on start, with row_now=0 and col_now=0 on entry; if start and stop are asserted in the same cycle in IDLE, start SHALL take effect and stop SHALL be ignored.
REQ-019 In SCAN, pix_valid SHALL be 1; the scan position SHALL advance only in cycles with pix_valid&&pix_ready and SHALL hold otherwise.
REQ-020 On an advance: col_now<COLS-1 -> col_now+1; otherwise col_now->0 and row_now+1.
REQ-021 An advance at (ROWS-1, COLS-1) SHALL move the FSM to FEND, with row_now and col_now returning to 0.
REQ-022 FEND SHALL last exactly one cycle, with frame_done=1 and pix_valid=0.
REQ-023 From FEND, the FSM SHALL go to IDLE if a stop is pending, else to SCAN.
REQ-024 A stop pulse in any non-IDLE state SHALL set a pending flag; the pending flag SHALL clear on entry to IDLE, and the current frame SHALL always complete.
REQ-025 pix_on SHALL be combinational with zero latency from the judge inputs: stage0 = judge1; stage1 = judge1|judge2; stage2 = judge1|judge2|judge3; stage3 = 0.
REQ-026 pix_on SHALL be 0 whenever pix_valid=0.
REQ-027 An 8-bit frame counter SHALL increment in FEND; when it reaches HOLD_FRAMES-1 it SHALL reset to 0 and stage SHALL increment, wrapping 3->0.
REQ-028 The frame counter and stage SHALL persist through IDLE; start SHALL NOT clear them.
REQ-029 No output SHALL change on a stalled cycle (pix_ready=0).
REQ-030 Row and column counters SHALL never exceed ROWS-1 and COLS-1 respectively.

Reset
REQ-031 On rst_n=0, at any time including mid-frame, the block SHALL immediately enter IDLE with row_now=0, col_now=0, stage=0, frame counter=0, stop-pending=0, pix_valid=0, pix_on=0, frame_done=0 and busy=0.
REQ-032 After rst_n is released, the block SHALL remain in IDLE until start is asserted.

Verification
REQ-033 Scan order: ROWS=3, COLS=4, pix_ready=1, start pulse -> 12 consecutive pix_valid cycles visiting (0,0)..(0,3),(1,0)..(2,3), then one frame_done cycle, then (0,0) again.
REQ-034 Backpressure: pix_ready toggled 1,0,0,1 at (1,2) -> (1,2) is held for 3 cycles, followed by (1,3), with pix_on unchanged while held.
REQ-035 Stage walk: HOLD_FRAMES=2, judge1=judge2=judge3=1 constant -> pix_on=1 for frames 0-5, pix_on=0 for frames 6-7, stage sequence 0,0,1,1,2,2,3,3,0.
REQ-036 Ring select: stage=1 with judge3=1 only at (52,0) -> pix_on=0 at (52,0); with stage=2 -> pix_on=1 at (52,0).
REQ-037 Stop: stop pulse at (0,1) -> frame completes, frame_done pulses, then IDLE with busy=0 and stage/frame counter retained; start and stop together in IDLE -> scanning begins.
REQ-038 Reset mid-operation: rst_n pulled low at (1,1) in stage 2 -> all outputs zero within the same cycle; after release, outputs stay zero until start.
